matrix_result_serializer: RTL and testbench

Drains one packed 4x4 result matrix (16 elements × 32 bits = 512 bits) from the multiplier's `result` bus and streams it out one element per transfer over a valid/ready handshake. It sits downstream of the multiplier. It captures a snapshot on `load`, so the multiplier may recompute while the previous result is still draining. Element k of the packed bus occupies bits [32k+31:32k], at row k/4, column k%4.

---
 rtl/matrix_result_serializer.sv | 125 ++++++++++++
 tb/tb_matrix_result_serializer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_result_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : matrix_result_serializer
// Description : Snapshots a packed 4x4 result matrix on load and streams it
//               out one element per valid/ready transfer.
//               Define RESULT_TRANSPOSE_EN for column-major (transposed) order.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_result_serializer #(
    parameter int ELEM_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [16*ELEM_W-1:0]  result,
    input  logic                  load,
    output logic                  busy,
    output logic [ELEM_W-1:0]     out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            out_row,
    output logic [1:0]            out_col,
    output logic                  out_last,
    output logic                  done,
    output logic                  overrun
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    localparam logic [3:0] c_LAST_IDX = 4'd15;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [3:0]             r_idx;
    logic [3:0]             w_idx_nxt;
    logic [3:0]             w_pos_nxt;
    logic [16*ELEM_W-1:0]   r_shadow;
    logic [16*ELEM_W-1:0]   w_shadow_nxt;
    logic [ELEM_W-1:0]      w_elem_nxt;
    logic                   w_xfer;
    logic                   w_final;
    logic                   w_accept;
    logic                   w_overrun_nxt;

    // Outputs are registered from next-state values so a reload on the final
    // handshake presents the new element 0 without a bubble.
    always_comb begin
        w_xfer        = out_valid & out_ready;
        w_final       = w_xfer && (r_idx == c_LAST_IDX);
        w_accept      = load && ((r_state == ST_IDLE) || w_final);
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_shadow_nxt  = r_shadow;
        w_overrun_nxt = overrun;
        if (w_accept) begin
            w_state_nxt   = ST_STREAM;
            w_idx_nxt     = 4'd0;
            w_shadow_nxt  = result;
            w_overrun_nxt = 1'b0;
        end else if (w_final) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = 4'd0;
        end else if (w_xfer) begin
            w_idx_nxt = r_idx + 4'd1;
        end
        if (load && !w_accept) begin
            w_overrun_nxt = 1'b1;
        end
    end

`ifdef RESULT_TRANSPOSE_EN
    assign w_pos_nxt = {w_idx_nxt[1:0], w_idx_nxt[3:2]};
`else
    assign w_pos_nxt = w_idx_nxt;
`endif

    always_comb begin
        w_elem_nxt = '0;
        for (int i = 0; i < 16; i++) begin
            if (w_pos_nxt == 4'(i)) begin
                w_elem_nxt = w_shadow_nxt[i*ELEM_W +: ELEM_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_idx     <= 4'd0;
            r_shadow  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_data  <= '0;
            out_row   <= 2'd0;
            out_col   <= 2'd0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_shadow  <= w_shadow_nxt;
            out_valid <= (w_state_nxt == ST_STREAM);
            busy      <= (w_state_nxt == ST_STREAM);
            done      <= w_final;
            overrun   <= w_overrun_nxt;
            if (w_state_nxt == ST_STREAM) begin
                out_data <= w_elem_nxt;
                out_row  <= w_pos_nxt[3:2];
                out_col  <= w_pos_nxt[1:0];
                out_last <= (w_idx_nxt == c_LAST_IDX);
            end else begin
                out_data <= '0;
                out_row  <= 2'd0;
                out_col  <= 2'd0;
                out_last <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_result_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_matrix_result_serializer
// Description : Self-checking bench for matrix_result_serializer against an
//               element-order model (honours RESULT_TRANSPOSE_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_result_serializer;

    logic         clk = 1'b0;
    logic         reset;
    logic [511:0] result;
    logic         load;
    logic         out_ready;
    logic         busy;
    logic [31:0]  out_data;
    logic         out_valid;
    logic [1:0]   out_row;
    logic [1:0]   out_col;
    logic         out_last;
    logic         done;
    logic         overrun;

    int n_checks = 0;
    int n_fail   = 0;

    matrix_result_serializer #(.ELEM_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .result    (result),
        .load      (load),
        .busy      (busy),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .done      (done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // {valid, busy, last, row, col, data, done}
    logic [39:0] obs;
    assign obs = {out_valid, busy, out_last, out_row, out_col, out_data, done};

    function automatic int pos(input int i);
`ifdef RESULT_TRANSPOSE_EN
        return (i % 4) * 4 + i / 4;
`else
        return i;
`endif
    endfunction

    function automatic logic [39:0] exp_word(input logic [511:0] mat, input int i);
        int p;
        p = pos(i);
        return {1'b1, 1'b1, (i == 15), 2'(p / 4), 2'(p % 4), mat[p*32 +: 32], 1'b0};
    endfunction

    function automatic logic [511:0] fill(input logic [31:0] base);
        logic [511:0] m;
        for (int k = 0; k < 16; k++) m[k*32 +: 32] = base + 32'(k);
        return m;
    endfunction

    function automatic logic [511:0] rand_mat();
        logic [511:0] m;
        for (int k = 0; k < 16; k++) m[k*32 +: 32] = $urandom;
        return m;
    endfunction

    task automatic test_reset();
        logic [511:0] mat;
        reset = 1'b0; load = 1'b0; out_ready = 1'b0; result = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({obs, overrun} !== 41'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected 0", {obs, overrun});
        end
        reset = 1'b1;
        @(negedge clk);
        mat = fill(32'h1000_0000);
        result = mat; load = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (obs !== exp_word(mat, 5)) begin
            n_fail++;
            $display("FAIL pre_reset_idx5: got %h expected %h", obs, exp_word(mat, 5));
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({obs, overrun} !== 41'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected 0", {obs, overrun});
        end
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if ({obs, overrun} !== 41'b0) begin
                n_fail++;
                $display("FAIL post_reset_idle[%0d]: got %h expected 0", c, {obs, overrun});
            end
        end
    endtask

    task automatic test_row_major(input logic [511:0] mat);
        result = mat; load = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        load = 1'b0;
        result = rand_mat();
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (obs !== exp_word(mat, i)) begin
                n_fail++;
                $display("FAIL stream[%0d]: got %h expected %h", i, obs, exp_word(mat, i));
            end
            @(negedge clk);
        end
        n_checks++;
        if (obs !== 40'h1) begin
            n_fail++;
            $display("FAIL stream_done: got %h expected %h", obs, 40'h1);
        end
        @(negedge clk);
        n_checks++;
        if (obs !== 40'h0) begin
            n_fail++;
            $display("FAIL stream_done_pulse: got %h expected 0", obs);
        end
    endtask

    task automatic test_backpressure(input logic [511:0] mat);
        int n = 0;
        result = mat; load = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int c = 0; c < 100 && n < 16; c++) begin
            n_checks++;
            if (obs !== exp_word(mat, n)) begin
                n_fail++;
                $display("FAIL bp[%0d] cyc %0d: got %h expected %h", n, c, obs, exp_word(mat, n));
            end
            out_ready = (c % 3 == 0);
            if (out_ready) n++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        n_checks++;
        if (n != 16) begin
            n_fail++;
            $display("FAIL bp_timeout: transferred %0d expected 16", n);
        end
        n_checks++;
        if (obs !== 40'h1) begin
            n_fail++;
            $display("FAIL bp_done: got %h expected %h", obs, 40'h1);
        end
        @(negedge clk);
    endtask

    task automatic test_overrun(input logic [511:0] mat, input logic [511:0] mat2);
        result = mat; load = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (obs !== exp_word(mat, i)) begin
                n_fail++;
                $display("FAIL ovr_stream[%0d]: got %h expected %h", i, obs, exp_word(mat, i));
            end
            n_checks++;
            if (overrun !== (i > 7)) begin
                n_fail++;
                $display("FAIL ovr_flag[%0d]: got %b expected %b", i, overrun, (i > 7));
            end
            load = (i == 7);
            if (i == 7) result = mat2;
            @(negedge clk);
        end
        n_checks++;
        if ({obs, overrun} !== 41'h3) begin
            n_fail++;
            $display("FAIL ovr_done: got %h expected %h", {obs, overrun}, 41'h3);
        end
        result = mat2; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        n_checks++;
        if ({overrun, obs} !== {1'b0, exp_word(mat2, 0)}) begin
            n_fail++;
            $display("FAIL ovr_clear: got %h expected %h", {overrun, obs}, {1'b0, exp_word(mat2, 0)});
        end
        repeat (17) @(negedge clk);
    endtask

    task automatic test_back_to_back(input logic [511:0] m1, input logic [511:0] m2);
        result = m1; load = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (obs !== exp_word(m1, i)) begin
                n_fail++;
                $display("FAIL b2b_first[%0d]: got %h expected %h", i, obs, exp_word(m1, i));
            end
            if (i == 15) begin
                load = 1'b1; result = m2;
            end
            @(negedge clk);
        end
        load = 1'b0;
        n_checks++;
        if (obs !== (exp_word(m2, 0) | 40'h1)) begin
            n_fail++;
            $display("FAIL b2b_seam: got %h expected %h", obs, exp_word(m2, 0) | 40'h1);
        end
        @(negedge clk);
        for (int i = 1; i < 16; i++) begin
            n_checks++;
            if (obs !== exp_word(m2, i)) begin
                n_fail++;
                $display("FAIL b2b_second[%0d]: got %h expected %h", i, obs, exp_word(m2, i));
            end
            @(negedge clk);
        end
        n_checks++;
        if (obs !== 40'h1) begin
            n_fail++;
            $display("FAIL b2b_done: got %h expected %h", obs, 40'h1);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_row_major(fill(32'h1000_0000));
        test_row_major(rand_mat());
        test_backpressure(fill(32'h1000_0000));
        test_backpressure(rand_mat());
        test_overrun(fill(32'h1000_0000), fill(32'h1000_0040));
        test_back_to_back(fill(32'h1000_0000), fill(32'h1000_0020));
        test_back_to_back(rand_mat(), rand_mat());
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
